// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the RV32M divide sequencer: ALUOp codes for the divide ops,
// controller state encoding and small op-decode helpers.
package div_sequencer_pkg;

    // Mirror of the CPU ALUOp encodings for the four RV32M divide operations.
    localparam logic [4:0] ALU_DIV  = 5'd12;
    localparam logic [4:0] ALU_DIVU = 5'd13;
    localparam logic [4:0] ALU_REM  = 5'd14;
    localparam logic [4:0] ALU_REMU = 5'd15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_RESP = 2'd2
    } div_state_e;

    function automatic logic is_div_op(input logic [4:0] op);
        return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
    endfunction

    function automatic logic is_signed_op(input logic [4:0] op);
        return (op == ALU_DIV) || (op == ALU_REM);
    endfunction

    function automatic logic is_rem_op(input logic [4:0] op);
        return (op == ALU_REM) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/div_operand_prep.sv
// Combinational operand conditioning: unsigned magnitudes for the core, result sign
// flags and detection of the RISC-V divide-by-zero / signed-overflow special cases.
module div_operand_prep #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            is_signed,
    output logic [XLEN-1:0] mag_a,
    output logic [XLEN-1:0] mag_b,
    output logic            neg_q,
    output logic            neg_r,
    output logic            div_by_zero,
    output logic            overflow
);

    localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};

    logic a_neg_s;
    logic b_neg_s;

    // Magnitudes, sign fix-up flags and special-case detection.
    always_comb begin
        a_neg_s = is_signed & a[XLEN-1];
        b_neg_s = is_signed & b[XLEN-1];
        if (a_neg_s) begin
            mag_a = ZERO - a;
        end else begin
            mag_a = a;
        end
        if (b_neg_s) begin
            mag_b = ZERO - b;
        end else begin
            mag_b = b;
        end
        neg_q       = is_signed & (a[XLEN-1] ^ b[XLEN-1]);
        neg_r       = a_neg_s;
        div_by_zero = (b == ZERO);
        overflow    = is_signed & (a == MIN_INT) & (b == ALL_ONES);
    end

endmodule

// File: rtl/div_sequencer.sv
// Sequencer between EX and an external iterative unsigned divider: resolves special
// cases and cache hits directly, otherwise runs the core and sign-corrects its result.
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int TIMEOUT  = 40,
    parameter int CACHE_EN = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ex_valid,
    input  logic [4:0]      ex_op,
    input  logic [XLEN-1:0] ex_a,
    input  logic [XLEN-1:0] ex_b,
    input  logic [4:0]      ex_rd,
    input  logic            flush,
    output logic            stall,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            wb_err,
    output logic            core_start,
    output logic            core_abort,
    output logic [XLEN-1:0] core_a,
    output logic [XLEN-1:0] core_b,
    input  logic            core_done,
    input  logic [XLEN-1:0] core_quo,
    input  logic [XLEN-1:0] core_rem
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e state_r;
    div_state_e state_nx_s;

    logic            req_s;
    logic            ex_signed_s;
    logic            ex_rem_s;
    logic [XLEN-1:0] mag_a_s;
    logic [XLEN-1:0] mag_b_s;
    logic            neg_q_s;
    logic            neg_r_s;
    logic            dbz_s;
    logic            ovf_s;
    logic            cache_hit_s;
    logic            fast_s;
    logic [XLEN-1:0] fast_q_s;
    logic [XLEN-1:0] fast_r_s;
    logic            timeout_s;
    logic [XLEN-1:0] quo_fix_s;
    logic [XLEN-1:0] rem_fix_s;
    logic            stall_s;
    logic            abort_s;

    logic [4:0]      rd_r;
    logic            rem_op_r;
    logic            sgn_r;
    logic            neg_q_r;
    logic            neg_r_r;
    logic [XLEN-1:0] a_r;
    logic [XLEN-1:0] b_r;
    logic [XLEN-1:0] result_r;
    logic            err_r;
    logic [CW-1:0]   cnt_r;
    logic            core_start_r;
    logic [XLEN-1:0] core_a_r;
    logic [XLEN-1:0] core_b_r;

    logic            cache_vld_r;
    logic            cache_sgn_r;
    logic [XLEN-1:0] cache_a_r;
    logic [XLEN-1:0] cache_b_r;
    logic [XLEN-1:0] cache_q_r;
    logic [XLEN-1:0] cache_rem_r;

    div_operand_prep #(.XLEN(XLEN)) u_prep (
        .a           (ex_a),
        .b           (ex_b),
        .is_signed   (ex_signed_s),
        .mag_a       (mag_a_s),
        .mag_b       (mag_b_s),
        .neg_q       (neg_q_s),
        .neg_r       (neg_r_s),
        .div_by_zero (dbz_s),
        .overflow    (ovf_s)
    );

    // Request decode, fast-path selection and core result sign fix-up.
    always_comb begin
        req_s       = ex_valid & is_div_op(ex_op) & ~flush;
        ex_signed_s = is_signed_op(ex_op);
        ex_rem_s    = is_rem_op(ex_op);
        cache_hit_s = (CACHE_EN != 0) & cache_vld_r & (ex_a == cache_a_r)
                    & (ex_b == cache_b_r) & (ex_signed_s == cache_sgn_r);
        fast_s      = dbz_s | ovf_s | cache_hit_s;
        // Divide-by-zero outranks overflow; neither ever reaches the cache.
        if (dbz_s) begin
            fast_q_s = ALL_ONES;
            fast_r_s = ex_a;
        end else if (ovf_s) begin
            fast_q_s = MIN_INT;
            fast_r_s = ZERO;
        end else begin
            fast_q_s = cache_q_r;
            fast_r_s = cache_rem_r;
        end
        if (neg_q_r) begin
            quo_fix_s = ZERO - core_quo;
        end else begin
            quo_fix_s = core_quo;
        end
        if (neg_r_r) begin
            rem_fix_s = ZERO - core_rem;
        end else begin
            rem_fix_s = core_rem;
        end
        timeout_s = (cnt_r == CW'(TIMEOUT - 1));
    end

    // Next state, pipeline stall and core abort; flush outranks done, done outranks timeout.
    always_comb begin
        state_nx_s = state_r;
        stall_s    = 1'b0;
        abort_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_s) begin
                    stall_s = 1'b1;
                    if (fast_s) begin
                        state_nx_s = ST_RESP;
                    end else begin
                        state_nx_s = ST_RUN;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                stall_s = 1'b1;
                if (flush) begin
                    abort_s    = 1'b1;
                    state_nx_s = ST_IDLE;
                end else if (core_done) begin
                    state_nx_s = ST_RESP;
                end else if (timeout_s) begin
                    abort_s    = 1'b1;
                    state_nx_s = ST_RESP;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_RESP: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Operation latch, core interface, result and cache registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_r         <= 5'd0;
            rem_op_r     <= 1'b0;
            sgn_r        <= 1'b0;
            neg_q_r      <= 1'b0;
            neg_r_r      <= 1'b0;
            a_r          <= ZERO;
            b_r          <= ZERO;
            result_r     <= ZERO;
            err_r        <= 1'b0;
            cnt_r        <= {CW{1'b0}};
            core_start_r <= 1'b0;
            core_a_r     <= ZERO;
            core_b_r     <= ZERO;
            cache_vld_r  <= 1'b0;
            cache_sgn_r  <= 1'b0;
            cache_a_r    <= ZERO;
            cache_b_r    <= ZERO;
            cache_q_r    <= ZERO;
            cache_rem_r  <= ZERO;
        end else begin
            core_start_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req_s) begin
                        rd_r     <= ex_rd;
                        rem_op_r <= ex_rem_s;
                        sgn_r    <= ex_signed_s;
                        neg_q_r  <= neg_q_s;
                        neg_r_r  <= neg_r_s;
                        a_r      <= ex_a;
                        b_r      <= ex_b;
                        err_r    <= 1'b0;
                        cnt_r    <= {CW{1'b0}};
                        if (fast_s) begin
                            result_r <= ex_rem_s ? fast_r_s : fast_q_s;
                        end else begin
                            core_a_r     <= mag_a_s;
                            core_b_r     <= mag_b_s;
                            core_start_r <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    cnt_r <= cnt_r + CW'(1);
                    if (flush) begin
                        cache_vld_r <= 1'b0;
                    end else if (core_done) begin
                        result_r    <= rem_op_r ? rem_fix_s : quo_fix_s;
                        cache_vld_r <= (CACHE_EN != 0);
                        cache_sgn_r <= sgn_r;
                        cache_a_r   <= a_r;
                        cache_b_r   <= b_r;
                        cache_q_r   <= quo_fix_s;
                        cache_rem_r <= rem_fix_s;
                    end else if (timeout_s) begin
                        result_r <= ZERO;
                        err_r    <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign stall      = stall_s;
    assign core_abort = abort_s;
    assign core_start = core_start_r;
    assign core_a     = core_a_r;
    assign core_b     = core_b_r;
    assign wb_valid   = (state_r == ST_RESP) & ~flush;
    assign wb_rd      = (state_r == ST_RESP) ? rd_r : 5'd0;
    assign wb_data    = (state_r == ST_RESP) ? result_r : ZERO;
    assign wb_err     = (state_r == ST_RESP) & err_r;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer with a behavioural divider core whose done delay
// is programmable; vectors carry hand-computed results, latencies and stall counts.
module tb_div_sequencer;
    import div_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic [4:0]  ex_op;
    logic [31:0] ex_a;
    logic [31:0] ex_b;
    logic [4:0]  ex_rd;
    logic        flush;
    logic        stall;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_err;
    logic        core_start;
    logic        core_abort;
    logic [31:0] core_a;
    logic [31:0] core_b;
    logic        core_done;
    logic [31:0] core_quo;
    logic [31:0] core_rem;

    int n_chk = 0;
    int n_err = 0;

    // Behavioural core state
    int          core_delay = 0;
    int          m_cnt;
    logic        m_busy;
    logic        m_done;
    logic        inj_done;
    logic [31:0] m_a;
    logic [31:0] m_b;
    int          busy_viol = 0;

    always #5 clk = ~clk;

    div_sequencer #(.XLEN(32), .TIMEOUT(40), .CACHE_EN(1)) dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_op(ex_op), .ex_a(ex_a),
        .ex_b(ex_b), .ex_rd(ex_rd), .flush(flush), .stall(stall), .wb_valid(wb_valid),
        .wb_rd(wb_rd), .wb_data(wb_data), .wb_err(wb_err), .core_start(core_start),
        .core_abort(core_abort), .core_a(core_a), .core_b(core_b), .core_done(core_done),
        .core_quo(core_quo), .core_rem(core_rem)
    );

    assign core_done = m_done | inj_done;
    assign core_quo  = (m_b == 32'd0) ? 32'hFFFF_FFFF : m_a / m_b;
    assign core_rem  = (m_b == 32'd0) ? m_a : m_a % m_b;

    // Core model: done arrives core_delay cycles after the start cycle (0 = never).
    always @(posedge clk) begin
        if (reset) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_cnt  <= 0;
        end else begin
            m_done <= 1'b0;
            if (core_abort) begin
                m_busy <= 1'b0;
            end else if (core_start) begin
                if (m_busy) busy_viol <= busy_viol + 1;
                m_a   <= core_a;
                m_b   <= core_b;
                m_cnt <= 1;
                if (core_delay == 1) begin
                    m_done <= 1'b1;
                    m_busy <= 1'b0;
                end else begin
                    m_busy <= 1'b1;
                end
            end else if (m_busy) begin
                if (core_delay != 0 && m_cnt == core_delay - 1) begin
                    m_done <= 1'b1;
                    m_busy <= 1'b0;
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            end
        end
    end

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          dly;
        logic [31:0] data;
        logic        err;
        int          lat;
        int          stl;
        int          starts;
        int          abort_at;
        logic        chk_core;
        logic [31:0] ca;
        logic [31:0] cb;
    } vec_t;

    function automatic vec_t fast(input logic [4:0] op, input logic [31:0] a,
                                  input logic [31:0] b, input logic [31:0] data);
        vec_t v;
        v = '{op, a, b, 0, data, 1'b0, 2, 1, 0, 0, 1'b0, 32'd0, 32'd0};
        return v;
    endfunction

    function automatic vec_t slow(input logic [4:0] op, input logic [31:0] a,
                                  input logic [31:0] b, input int dly, input logic [31:0] data,
                                  input logic [31:0] ca, input logic [31:0] cb);
        vec_t v;
        v = '{op, a, b, dly, data, 1'b0, dly + 3, dly + 2, 1, 0, 1'b1, ca, cb};
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v, input logic [4:0] rd, input string name);
        int          lat = 0;
        int          stalls = 0;
        int          starts = 0;
        int          abort_at = 0;
        logic        got = 1'b0;
        logic [31:0] data = 32'd0;
        logic [4:0]  wrd = 5'd0;
        logic        err = 1'b0;
        logic [31:0] ca = 32'd0;
        logic [31:0] cb = 32'd0;
        core_delay = v.dly;
        @(posedge clk); #1;
        ex_valid = 1'b1; ex_op = v.op; ex_a = v.a; ex_b = v.b; ex_rd = rd;
        for (int cyc = 1; cyc <= 100 && !got; cyc++) begin
            @(negedge clk);
            if (stall) stalls++;
            if (core_start) begin starts++; ca = core_a; cb = core_b; end
            if (core_abort) abort_at = cyc;
            if (wb_valid) begin got = 1'b1; lat = cyc; data = wb_data; wrd = wb_rd; err = wb_err; end
            @(posedge clk); #1;
        end
        ex_valid = 1'b0;
        chk({name, "_wb_seen"}, {31'd0, got}, 32'd1);
        chk({name, "_data"}, data, v.data);
        chk({name, "_rd"}, {27'd0, wrd}, {27'd0, rd});
        chk({name, "_err"}, {31'd0, err}, {31'd0, v.err});
        chk({name, "_latency"}, lat, v.lat);
        chk({name, "_stall_cycles"}, stalls, v.stl);
        chk({name, "_core_starts"}, starts, v.starts);
        chk({name, "_abort_cycle"}, abort_at, v.abort_at);
        if (v.chk_core) begin
            chk({name, "_core_a"}, ca, v.ca);
            chk({name, "_core_b"}, cb, v.cb);
        end
        @(negedge clk);
        chk({name, "_wb_one_cycle"}, {31'd0, wb_valid}, 32'd0);
    endtask

    vec_t vecs[14];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0]  = slow(ALU_DIVU, 32'd100, 32'd7, 32, 32'd14, 32'd100, 32'd7);
        vecs[1]  = fast(ALU_REMU, 32'd100, 32'd7, 32'd2);
        vecs[2]  = slow(ALU_DIV, 32'hFFFF_FF9C, 32'd7, 4, 32'hFFFF_FFF2, 32'd100, 32'd7);
        vecs[3]  = fast(ALU_REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE);
        vecs[4]  = fast(ALU_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF);
        vecs[5]  = fast(ALU_REM, 32'd5, 32'd0, 32'd5);
        vecs[6]  = fast(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        vecs[7]  = fast(ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        vecs[8]  = slow(ALU_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 3, 32'd0, 32'h8000_0000, 32'hFFFF_FFFF);
        vecs[9]  = slow(ALU_DIV, 32'd7, 32'hFFFF_FFFE, 2, 32'hFFFF_FFFD, 32'd7, 32'd2);
        vecs[10] = fast(ALU_REM, 32'd7, 32'hFFFF_FFFE, 32'd1);
        // Core never answers: abort in RUN cycle 40, error writeback one cycle later.
        vecs[11] = '{ALU_DIVU, 32'd9, 32'd3, 0, 32'd0, 1'b1, 42, 41, 1, 41, 1'b1, 32'd9, 32'd3};
        vecs[12] = slow(ALU_DIVU, 32'd9, 32'd3, 2, 32'd3, 32'd9, 32'd3);
        vecs[13] = fast(ALU_REMU, 32'd9, 32'd3, 32'd0);

        reset = 1'b1; ex_valid = 1'b0; ex_op = 5'd0; ex_a = 32'd0; ex_b = 32'd0;
        ex_rd = 5'd0; flush = 1'b0; inj_done = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ctrl", {22'd0, stall, wb_valid, wb_err, core_start, core_abort, wb_rd}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_core_a", core_a, 32'd0);
        chk("rst_core_b", core_b, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i], 5'(i + 1), $sformatf("v%0d", i));
        end

        // Non-divide op: no stall, no writeback
        @(posedge clk); #1;
        ex_valid = 1'b1; ex_op = 5'd0; ex_a = 32'd100; ex_b = 32'd7;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("nondiv_stall", {31'd0, stall}, 32'd0);
            chk("nondiv_wb", {31'd0, wb_valid}, 32'd0);
            @(posedge clk); #1;
        end
        ex_valid = 1'b0;

        // Flush in RUN cycle 10: abort, no writeback, cache dropped
        core_delay = 32;
        @(posedge clk); #1;
        ex_valid = 1'b1; ex_op = ALU_DIVU; ex_a = 32'd1000; ex_b = 32'd3; ex_rd = 5'd17;
        repeat (10) @(posedge clk);
        #1; flush = 1'b1; ex_valid = 1'b0;
        @(negedge clk);
        chk("flush_abort", {31'd0, core_abort}, 32'd1);
        chk("flush_wb", {31'd0, wb_valid}, 32'd0);
        @(posedge clk); #1; flush = 1'b0;
        @(negedge clk);
        chk("flush_abort_once", {31'd0, core_abort}, 32'd0);
        chk("flush_idle_stall", {31'd0, stall}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            chk("flush_no_wb", {31'd0, wb_valid}, 32'd0);
            @(negedge clk);
        end
        run_op(slow(ALU_REMU, 32'd9, 32'd3, 2, 32'd0, 32'd9, 32'd3), 5'd18, "flush_inval");
        run_op(slow(ALU_REMU, 32'd1000, 32'd3, 5, 32'd1, 32'd1000, 32'd3), 5'd19, "flush_rerun");
        run_op(slow(ALU_DIVU, 32'd50, 32'd5, 2, 32'd10, 32'd50, 32'd5), 5'd20, "pre_reset");

        // Reset in RUN cycle 6, then a late done must be ignored
        core_delay = 20;
        @(posedge clk); #1;
        ex_valid = 1'b1; ex_op = ALU_DIVU; ex_a = 32'd60; ex_b = 32'd7; ex_rd = 5'd21;
        repeat (6) @(posedge clk);
        #1; reset = 1'b1; ex_valid = 1'b0;
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        chk("midrst_ctrl", {22'd0, stall, wb_valid, wb_err, core_start, core_abort, wb_rd}, 32'd0);
        chk("midrst_wb_data", wb_data, 32'd0);
        chk("midrst_core_a", core_a, 32'd0);
        chk("midrst_core_b", core_b, 32'd0);
        @(posedge clk); #1; inj_done = 1'b1;
        @(negedge clk);
        chk("late_done_stall", {31'd0, stall}, 32'd0);
        chk("late_done_wb0", {31'd0, wb_valid}, 32'd0);
        @(posedge clk); #1; inj_done = 1'b0;
        @(negedge clk);
        chk("late_done_wb1", {31'd0, wb_valid}, 32'd0);
        run_op(slow(ALU_REMU, 32'd50, 32'd5, 2, 32'd0, 32'd50, 32'd5), 5'd22, "post_reset");

        chk("start_while_busy", busy_viol, 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
